// File: rtl/img_pkg.sv
// Shared definitions for the 64x64 RGB frame store: geometry, pixel field
// layout and controller state encoding.
package img_pkg;

   localparam int IMG_DIM_W  = 6;
   localparam int IMG_PIX_W  = 24;
   localparam int IMG_ADDR_W = 2 * IMG_DIM_W;
   localparam int IMG_NPIX   = 4096;

   localparam int IMG_R_HI = 23;
   localparam int IMG_R_LO = 16;
   localparam int IMG_G_HI = 15;
   localparam int IMG_G_LO = 8;
   localparam int IMG_B_HI = 7;
   localparam int IMG_B_LO = 0;

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_PROC = 2'd1,
      ST_DUMP = 2'd2
   } img_state_t;

   function automatic logic [IMG_PIX_W-1:0] img_rgb(input logic [7:0] r,
                                                    input logic [7:0] g,
                                                    input logic [7:0] b);
      logic [IMG_PIX_W-1:0] p;
      p = '0;
      p[IMG_R_HI:IMG_R_LO] = r;
      p[IMG_G_HI:IMG_G_LO] = g;
      p[IMG_B_HI:IMG_B_LO] = b;
      return p;
   endfunction

endpackage

// File: rtl/img_mem_2r1w.sv
// Frame array with two asynchronous read ports and one synchronous write port.
// Contents are intentionally not reset so a frame survives rst.
module img_mem_2r1w #(
   parameter int ADDR_W = 12,
   parameter int PIX_W  = 24
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [PIX_W-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr_a,
   output logic [PIX_W-1:0]  rdata_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [PIX_W-1:0]  rdata_b
);

   logic [PIX_W-1:0] mem [0:(1<<ADDR_W)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata_a = mem[raddr_a];
   assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/image_store.sv
// Frame store for the image processor: host load stream, in-place processor
// read/write, host dump stream, sequenced LOAD -> PROC -> DUMP with a watchdog.
//
// state   | meaning
// ST_LOAD | accept host pixels in raster order into the array
// ST_PROC | processor owns the array; watchdog counts cycles
// ST_DUMP | stream the array back to the host in raster order
module image_store
   import img_pkg::*;
#(
   parameter int DIM_W   = IMG_DIM_W,
   parameter int PIX_W   = IMG_PIX_W,
   parameter int TIMEOUT = 65535
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld_valid,
   output logic             ld_ready,
   input  logic [PIX_W-1:0] ld_pix,
   input  logic [DIM_W-1:0] row,
   input  logic [DIM_W-1:0] col,
   output logic [PIX_W-1:0] in_pix,
   input  logic             out_we,
   input  logic [PIX_W-1:0] out_pix,
   input  logic             proc_done,
   output logic             proc_go,
   output logic             dump_valid,
   input  logic             dump_ready,
   output logic [PIX_W-1:0] dump_pix,
   output logic             dump_last,
   output logic             err_timeout
);

   localparam int              ADDR_W     = 2 * DIM_W;
   localparam logic [ADDR_W-1:0] CNT_LAST = '1;
   localparam logic [15:0]     WDOG_LIMIT = 16'(TIMEOUT - 1);
   localparam bit              WDOG_EN    = (TIMEOUT != 0);

   img_state_t        state, state_nxt;
   logic [ADDR_W-1:0] cnt, cnt_nxt;
   logic [15:0]       wdog, wdog_nxt;
   logic              err_nxt;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [PIX_W-1:0]  mem_wdata;

   img_mem_2r1w #(
      .ADDR_W (ADDR_W),
      .PIX_W  (PIX_W)
   ) u_mem (
      .clk     (clk),
      .we      (mem_we),
      .waddr   (mem_waddr),
      .wdata   (mem_wdata),
      .raddr_a ({row, col}),
      .rdata_a (in_pix),
      .raddr_b (cnt),
      .rdata_b (dump_pix)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_LOAD;
         cnt         <= '0;
         wdog        <= '0;
         err_timeout <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         wdog        <= wdog_nxt;
         err_timeout <= err_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      wdog_nxt   = wdog;
      err_nxt    = err_timeout;
      ld_ready   = 1'b0;
      proc_go    = 1'b0;
      dump_valid = 1'b0;
      mem_we     = 1'b0;
      mem_waddr  = cnt;
      mem_wdata  = ld_pix;

      case (state)
         ST_LOAD: begin
            ld_ready = 1'b1;
            if (ld_valid) begin
               mem_we = 1'b1;
               if (cnt == CNT_LAST) begin
                  cnt_nxt   = '0;
                  state_nxt = ST_PROC;
                  wdog_nxt  = '0;
                  err_nxt   = 1'b0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end

         ST_PROC: begin
            proc_go   = 1'b1;
            mem_we    = out_we;
            mem_waddr = {row, col};
            mem_wdata = out_pix;
            if (wdog != '1) begin
               wdog_nxt = wdog + 1'b1;
            end
            // Completion wins over a watchdog expiry in the same cycle.
            if (proc_done) begin
               state_nxt = ST_DUMP;
            end else if (WDOG_EN && (wdog == WDOG_LIMIT)) begin
               err_nxt   = 1'b1;
               state_nxt = ST_DUMP;
            end
         end

         ST_DUMP: begin
            dump_valid = 1'b1;
            if (dump_ready) begin
               if (cnt == CNT_LAST) begin
                  cnt_nxt   = '0;
                  state_nxt = ST_LOAD;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end

         default: begin
            state_nxt = ST_LOAD;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign dump_last = (state == ST_DUMP) && (cnt == CNT_LAST);

endmodule

// File: tb/tb_image_store.sv
// Scoreboard bench for image_store: directed frames cover load, in-place
// write, ignored writes, dump back-pressure, watchdog abort and mid-dump reset.
module tb_image_store;
   import img_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 ld_valid;
   logic                 ld_ready;
   logic [IMG_PIX_W-1:0] ld_pix;
   logic [IMG_DIM_W-1:0] row;
   logic [IMG_DIM_W-1:0] col;
   logic [IMG_PIX_W-1:0] in_pix;
   logic                 out_we;
   logic [IMG_PIX_W-1:0] out_pix;
   logic                 proc_done;
   logic                 proc_go;
   logic                 dump_valid;
   logic                 dump_ready;
   logic [IMG_PIX_W-1:0] dump_pix;
   logic                 dump_last;
   logic                 err_timeout;

   int checks = 0;
   int errors = 0;

   logic [IMG_PIX_W-1:0] exp_mem [0:IMG_NPIX-1];
   logic [IMG_PIX_W:0]   sb [$];

   image_store #(.TIMEOUT(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .ld_valid    (ld_valid),
      .ld_ready    (ld_ready),
      .ld_pix      (ld_pix),
      .row         (row),
      .col         (col),
      .in_pix      (in_pix),
      .out_we      (out_we),
      .out_pix     (out_pix),
      .proc_done   (proc_done),
      .proc_go     (proc_go),
      .dump_valid  (dump_valid),
      .dump_ready  (dump_ready),
      .dump_pix    (dump_pix),
      .dump_last   (dump_last),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops one expected beat per dump handshake and checks hold during stalls.
   logic               stalled = 1'b0;
   logic [IMG_PIX_W:0] held;
   always @(negedge clk) begin
      if (!rst) begin
         if (stalled && dump_valid)
            check("dump_hold", {7'd0, dump_last, dump_pix}, {7'd0, held});
         stalled = dump_valid && !dump_ready;
         held    = {dump_last, dump_pix};
         if (dump_valid && dump_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL dump_extra: got beat %h expected none", {dump_last, dump_pix});
            end else begin
               check("dump_beat", {7'd0, dump_last, dump_pix}, {7'd0, sb.pop_front()});
            end
         end
      end else begin
         stalled = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_frame(input logic [IMG_PIX_W-1:0] base, input bit bad_we,
                             input bit exp_err_before);
      row     = '0;
      col     = '0;
      out_we  = bad_we;
      out_pix = 24'hFFFFFF;
      for (int i = 0; i < IMG_NPIX; i++) begin
         ld_valid   = 1'b1;
         ld_pix     = base ^ IMG_PIX_W'(i);
         exp_mem[i] = base ^ IMG_PIX_W'(i);
         if (i == 1) begin
            #1;
            check("in_pix_load", {8'd0, in_pix}, {8'd0, exp_mem[0]});
         end
         if (i == IMG_NPIX - 1) begin
            #1;
            check("ld_ready_last", {31'd0, ld_ready}, 32'd1);
            check("err_before_load_end", {31'd0, err_timeout}, {31'd0, exp_err_before});
         end
         tick();
      end
      ld_valid = 1'b0;
      out_we   = 1'b0;
      check("ld_ready_drop", {31'd0, ld_ready}, 32'd0);
      check("proc_go_on", {31'd0, proc_go}, 32'd1);
      check("err_after_load", {31'd0, err_timeout}, 32'd0);
   endtask

   task automatic push_dump(input int n);
      for (int i = 0; i < n; i++)
         sb.push_back({(i == IMG_NPIX - 1), exp_mem[i]});
   endtask

   task automatic run_dump(input bit stall_pat);
      int cyc;
      logic [3:0] pat;
      pat = 4'b1001;
      cyc = 0;
      while (sb.size() > 0 && cyc < 20000) begin
         dump_ready = stall_pat ? pat[3 - (cyc % 4)] : 1'b1;
         tick();
         cyc++;
      end
      dump_ready = 1'b0;
      check("dump_budget", {31'd0, (cyc < 20000)}, 32'd1);
   endtask

   task automatic simple_proc();
      check("proc_go_c1", {31'd0, proc_go}, 32'd1);
      tick();
      check("proc_go_c2", {31'd0, proc_go}, 32'd1);
      proc_done = 1'b1;
      tick();
      proc_done = 1'b0;
      check("proc_go_off", {31'd0, proc_go}, 32'd0);
      check("dump_valid_on", {31'd0, dump_valid}, 32'd1);
   endtask

   initial begin
      int n;
      logic [IMG_PIX_W-1:0] wpix;
      rst = 1'b1; ld_valid = 1'b0; ld_pix = '0; row = '0; col = '0;
      out_we = 1'b0; out_pix = '0; proc_done = 1'b0; dump_ready = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
      check("rst_proc_go", {31'd0, proc_go}, 32'd0);
      check("rst_dump_valid", {31'd0, dump_valid}, 32'd0);
      check("rst_dump_last", {31'd0, dump_last}, 32'd0);
      check("rst_err", {31'd0, err_timeout}, 32'd0);

      // Frame A: ramp load with stray writes, in-place write, stalled dump.
      load_frame(24'h000000, 1'b1, 1'b0);
      wpix = img_rgb(8'hAB, 8'hCD, 8'hEF);
      row = 6'd3; col = 6'd5; out_we = 1'b1; out_pix = wpix;
      #1;
      check("in_pix_old", {8'd0, in_pix}, {8'd0, 24'd197});
      check("proc_go_a1", {31'd0, proc_go}, 32'd1);
      tick();
      out_we = 1'b0;
      check("in_pix_new", {8'd0, in_pix}, {8'd0, 24'hABCDEF});
      check("proc_go_a2", {31'd0, proc_go}, 32'd1);
      exp_mem[197] = 24'hABCDEF;
      proc_done = 1'b1;
      tick();
      proc_done = 1'b0;
      check("proc_go_a_off", {31'd0, proc_go}, 32'd0);
      check("dump_valid_a", {31'd0, dump_valid}, 32'd1);
      push_dump(IMG_NPIX);
      run_dump(1'b1);
      check("dump_done_valid", {31'd0, dump_valid}, 32'd0);
      check("dump_done_ld_ready", {31'd0, ld_ready}, 32'd1);

      // Frame B: back-to-back load, watchdog abort after 16 PROC cycles.
      load_frame(24'h5A0000, 1'b0, 1'b0);
      n = 0;
      while (proc_go && n < 40) begin
         tick();
         n++;
      end
      check("wdog_cycles", n, 32'd16);
      check("wdog_dump", {31'd0, dump_valid}, 32'd1);
      check("wdog_err", {31'd0, err_timeout}, 32'd1);
      proc_done = 1'b1;
      push_dump(IMG_NPIX);
      run_dump(1'b0);
      proc_done = 1'b0;
      check("err_sticky", {31'd0, err_timeout}, 32'd1);

      // Frame C: error clears at load completion, then reset mid-dump at beat 100.
      load_frame(24'h330000, 1'b0, 1'b1);
      simple_proc();
      push_dump(100);
      run_dump(1'b0);
      rst = 1'b1;
      #1;
      check("mid_rst_ld_ready", {31'd0, ld_ready}, 32'd1);
      check("mid_rst_dump_valid", {31'd0, dump_valid}, 32'd0);
      check("mid_rst_dump_last", {31'd0, dump_last}, 32'd0);
      check("mid_rst_proc_go", {31'd0, proc_go}, 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // Frame D: full ramp cycle after the reset.
      load_frame(24'h000000, 1'b0, 1'b0);
      simple_proc();
      push_dump(IMG_NPIX);
      run_dump(1'b0);
      check("final_ld_ready", {31'd0, ld_ready}, 32'd1);
      check("sb_empty", sb.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
